// File: rtl/axi4_master_burst.sv
// Single-outstanding AXI4 master: turns one command plus a data stream into one INCR
// read or write burst, then reports the worst response and any protocol error.
module axi4_master_burst #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,

  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [7:0]              cmd_len,
  input  logic [ID_WIDTH-1:0]     cmd_id,

  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_strb,
  input  logic                    wr_valid,
  output logic                    wr_ready,

  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_last,
  output logic                    rd_valid,
  input  logic                    rd_ready,

  output logic                    done,
  output logic [1:0]              resp,
  output logic                    err,

  output logic [ID_WIDTH-1:0]     M_AXI_AWID,
  output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [7:0]              M_AXI_AWLEN,
  output logic [2:0]              M_AXI_AWSIZE,
  output logic [1:0]              M_AXI_AWBURST,
  output logic                    M_AXI_AWVALID,
  input  logic                    M_AXI_AWREADY,

  output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                    M_AXI_WLAST,
  output logic                    M_AXI_WVALID,
  input  logic                    M_AXI_WREADY,

  input  logic [ID_WIDTH-1:0]     M_AXI_BID,
  input  logic [1:0]              M_AXI_BRESP,
  input  logic                    M_AXI_BVALID,
  output logic                    M_AXI_BREADY,

  output logic [ID_WIDTH-1:0]     M_AXI_ARID,
  output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [7:0]              M_AXI_ARLEN,
  output logic [2:0]              M_AXI_ARSIZE,
  output logic [1:0]              M_AXI_ARBURST,
  output logic                    M_AXI_ARVALID,
  input  logic                    M_AXI_ARREADY,

  input  logic [ID_WIDTH-1:0]     M_AXI_RID,
  input  logic [DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]              M_AXI_RRESP,
  input  logic                    M_AXI_RLAST,
  input  logic                    M_AXI_RVALID,
  output logic                    M_AXI_RREADY
);

  localparam logic [2:0] AX_SIZE  = 3'($clog2(DATA_WIDTH / 8));
  localparam logic [1:0] AX_BURST = 2'b01;

  typedef enum logic [2:0] {IDLE, WR_AW, WR_W, WR_B, RD_AR, RD_R} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [1:0]            resp_q, resp_d;
  logic                  err_q, err_d;
  logic                  done_q, done_d;
  logic                  w_hs, r_hs;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      id_q    <= '0;
      resp_q  <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      resp_q  <= resp_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  // VALIDs on AW/AR depend only on state, so READY never feeds back into them.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    resp_d  = resp_q;
    err_d   = err_q;
    done_d  = 1'b0;

    cmd_ready     = (state_q == IDLE);
    M_AXI_AWVALID = (state_q == WR_AW);
    M_AXI_ARVALID = (state_q == RD_AR);
    M_AXI_WVALID  = (state_q == WR_W) && wr_valid;
    wr_ready      = (state_q == WR_W) && M_AXI_WREADY;
    M_AXI_WLAST   = M_AXI_WVALID && (cnt_q == len_q);
    M_AXI_BREADY  = (state_q == WR_B);
    M_AXI_RREADY  = (state_q == RD_R) && rd_ready;
    rd_valid      = (state_q == RD_R) && M_AXI_RVALID;
    rd_last       = (state_q == RD_R) && M_AXI_RLAST;
    w_hs          = M_AXI_WVALID && M_AXI_WREADY;
    r_hs          = rd_valid && M_AXI_RREADY;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          len_d   = cmd_len;
          id_d    = cmd_id;
          cnt_d   = '0;
          resp_d  = '0;
          err_d   = 1'b0;
          state_d = cmd_write ? WR_AW : RD_AR;
        end
      end
      WR_AW: if (M_AXI_AWREADY) state_d = WR_W;
      WR_W: begin
        if (w_hs) begin
          if (M_AXI_WLAST) state_d = WR_B;
          else             cnt_d   = cnt_q + 8'd1;
        end
      end
      WR_B: begin
        if (M_AXI_BVALID) begin
          resp_d  = M_AXI_BRESP;
          err_d   = (M_AXI_BID != id_q);
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      RD_AR: if (M_AXI_ARREADY) state_d = RD_R;
      RD_R: begin
        if (r_hs) begin
          if (M_AXI_RRESP > resp_q) resp_d = M_AXI_RRESP;
          // A mismatched ID or a LAST flag out of step with the length taints the burst.
          if ((M_AXI_RID != id_q) ||
              (M_AXI_RLAST && (cnt_q != len_q)) ||
              (!M_AXI_RLAST && (cnt_q == len_q)))
            err_d = 1'b1;
          if (M_AXI_RLAST) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign M_AXI_AWID    = id_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWLEN   = len_q;
  assign M_AXI_AWSIZE  = AX_SIZE;
  assign M_AXI_AWBURST = AX_BURST;
  assign M_AXI_ARID    = id_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARLEN   = len_q;
  assign M_AXI_ARSIZE  = AX_SIZE;
  assign M_AXI_ARBURST = AX_BURST;
  assign M_AXI_WDATA   = wr_data;
  assign M_AXI_WSTRB   = wr_strb;
  assign rd_data       = M_AXI_RDATA;
  assign done          = done_q;
  assign resp          = resp_q;
  assign err           = err_q;

endmodule

// File: tb/tb_axi4_master_burst.sv
// Bench for axi4_master_burst: directed bursts against a configurable slave, a
// handshake-level model compared every cycle, and literal latency/response checks.
module tb_axi4_master_burst;

  logic ACLK = 1'b0;
  logic ARESETN = 1'b0;
  always #5 ACLK = ~ACLK;

  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [7:0]  cmd_len = '0;
  logic [3:0]  cmd_id = '0;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_strb = '0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [31:0] rd_data;
  logic        rd_last, rd_valid;
  logic        rd_ready = 1'b0;
  logic        done;
  logic [1:0]  resp;
  logic        err;

  logic [3:0]  M_AXI_AWID;
  logic [31:0] M_AXI_AWADDR;
  logic [7:0]  M_AXI_AWLEN;
  logic [2:0]  M_AXI_AWSIZE;
  logic [1:0]  M_AXI_AWBURST;
  logic        M_AXI_AWVALID;
  logic        M_AXI_AWREADY = 1'b0;
  logic [31:0] M_AXI_WDATA;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_WLAST, M_AXI_WVALID;
  logic        M_AXI_WREADY = 1'b0;
  logic [3:0]  M_AXI_BID = '0;
  logic [1:0]  M_AXI_BRESP = '0;
  logic        M_AXI_BVALID = 1'b0;
  logic        M_AXI_BREADY;
  logic [3:0]  M_AXI_ARID;
  logic [31:0] M_AXI_ARADDR;
  logic [7:0]  M_AXI_ARLEN;
  logic [2:0]  M_AXI_ARSIZE;
  logic [1:0]  M_AXI_ARBURST;
  logic        M_AXI_ARVALID;
  logic        M_AXI_ARREADY = 1'b0;
  logic [3:0]  M_AXI_RID = '0;
  logic [31:0] M_AXI_RDATA = '0;
  logic [1:0]  M_AXI_RRESP = '0;
  logic        M_AXI_RLAST = 1'b0;
  logic        M_AXI_RVALID = 1'b0;
  logic        M_AXI_RREADY;

  axi4_master_burst #(.ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id),
    .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .done(done), .resp(resp), .err(err),
    .M_AXI_AWID(M_AXI_AWID), .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWLEN(M_AXI_AWLEN),
    .M_AXI_AWSIZE(M_AXI_AWSIZE), .M_AXI_AWBURST(M_AXI_AWBURST),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WLAST(M_AXI_WLAST),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BID(M_AXI_BID), .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID),
    .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARID(M_AXI_ARID), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN),
    .M_AXI_ARSIZE(M_AXI_ARSIZE), .M_AXI_ARBURST(M_AXI_ARBURST),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RID(M_AXI_RID), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RLAST(M_AXI_RLAST), .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int hs_cyc = 0;

  // Slave / stream behaviour knobs, written only by the main sequence.
  int         cfg_aw_stall = 0;
  bit         cfg_wgaps = 1'b0;
  bit         cfg_rtoggle = 1'b0;
  logic [1:0] cfg_bresp = '0;
  logic [3:0] cfg_bid = '0;
  logic [3:0] cfg_rid = '0;
  logic [1:0] cfg_rresp = '0;
  int         cfg_rresp_beat = 0;
  int         cfg_rlast_at = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge ACLK) cyc++;

  // Slave: handshakes are sampled mid-cycle and the response is driven just after the edge.
  int   aw_cyc = 0;
  int   rbeat = 0;
  bit   r_active = 1'b0;
  logic s_aw_hs, s_aw_wait, s_ar_hs, s_r_hs, s_rlast;
  always begin
    @(negedge ACLK);
    s_aw_hs   = M_AXI_AWVALID && M_AXI_AWREADY;
    s_aw_wait = M_AXI_AWVALID && !M_AXI_AWREADY;
    s_ar_hs   = M_AXI_ARVALID && M_AXI_ARREADY;
    s_r_hs    = M_AXI_RVALID && M_AXI_RREADY;
    s_rlast   = M_AXI_RLAST;
    @(posedge ACLK);
    #1;
    if (!ARESETN) begin
      aw_cyc = 0; r_active = 1'b0; rbeat = 0;
    end else begin
      if (s_aw_hs) aw_cyc = 0;
      else if (s_aw_wait) aw_cyc++;
      if (s_ar_hs) begin
        r_active = 1'b1; rbeat = 0;
      end else if (s_r_hs) begin
        if (s_rlast) r_active = 1'b0;
        rbeat++;
      end
    end
    M_AXI_AWREADY = (aw_cyc >= cfg_aw_stall);
    M_AXI_WREADY  = 1'b1;
    M_AXI_BVALID  = 1'b1;
    M_AXI_BRESP   = cfg_bresp;
    M_AXI_BID     = cfg_bid;
    M_AXI_ARREADY = 1'b1;
    M_AXI_RVALID  = r_active;
    M_AXI_RDATA   = 32'hD000_0000 + 32'(rbeat);
    M_AXI_RLAST   = r_active && (rbeat == cfg_rlast_at);
    M_AXI_RID     = cfg_rid;
    M_AXI_RRESP   = (rbeat == cfg_rresp_beat) ? cfg_rresp : 2'd0;
  end

  // Write stream source: holds each beat until it is taken, optional gaps.
  int   wbeat = 0;
  logic st_hs;
  always begin
    @(negedge ACLK);
    st_hs = wr_valid && wr_ready;
    @(posedge ACLK);
    #1;
    if (!ARESETN) begin
      wbeat = 0; wr_valid = 1'b0;
    end else begin
      if (st_hs) wbeat++;
      if (!wr_valid || st_hs) wr_valid = !(cfg_wgaps && (cyc % 3 == 0));
    end
    wr_data = 32'hA500_0000 + 32'(wbeat);
    wr_strb = 4'(wbeat) | 4'h1;
  end

  always begin
    @(posedge ACLK);
    #1;
    rd_ready = cfg_rtoggle ? ~rd_ready : 1'b1;
  end

  int rd_hs_cnt = 0;
  int rd_last_cnt = 0;
  always @(negedge ACLK) begin
    if (ARESETN && rd_valid && rd_ready) begin
      rd_hs_cnt++;
      if (rd_last) rd_last_cnt++;
    end
  end

  // Model: tracks burst progress as handshake counts and derives every output from them.
  bit         m_busy = 0, m_write = 0, m_addr_hs = 0, m_w_done = 0, m_done_pend = 0;
  int         m_len = 0, m_beats = 0;
  logic [31:0] m_addr = '0;
  logic [3:0]  m_id = '0;
  logic [1:0]  m_resp = '0;
  logic        m_err = 1'b0;
  logic ph_a, ph_w, ph_b, ph_r;
  logic e_aw, e_ar, e_wv, e_wl, e_wr, e_br, e_rr, e_rv, e_rl;

  always @(negedge ACLK) begin
    if (!ARESETN) begin
      m_busy = 0; m_done_pend = 0; m_resp = '0; m_err = 1'b0;
      checkOutput("rst_cmd_ready", cmd_ready, 1);
      checkOutput("rst_awvalid", M_AXI_AWVALID, 0);
      checkOutput("rst_arvalid", M_AXI_ARVALID, 0);
      checkOutput("rst_wvalid", M_AXI_WVALID, 0);
      checkOutput("rst_wlast", M_AXI_WLAST, 0);
      checkOutput("rst_bready", M_AXI_BREADY, 0);
      checkOutput("rst_rready", M_AXI_RREADY, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_resp", resp, 0);
      checkOutput("rst_err", err, 0);
    end else begin
      ph_a = m_busy && !m_addr_hs;
      ph_w = m_busy && m_write && m_addr_hs && !m_w_done;
      ph_b = m_busy && m_write && m_w_done;
      ph_r = m_busy && !m_write && m_addr_hs;
      e_aw = ph_a && m_write;
      e_ar = ph_a && !m_write;
      e_wv = ph_w && wr_valid;
      e_wl = e_wv && (m_beats == m_len);
      e_wr = ph_w && M_AXI_WREADY;
      e_br = ph_b;
      e_rr = ph_r && rd_ready;
      e_rv = ph_r && M_AXI_RVALID;
      e_rl = ph_r && M_AXI_RLAST;
      checkOutput("cmd_ready", cmd_ready, !m_busy);
      checkOutput("awvalid", M_AXI_AWVALID, e_aw);
      checkOutput("arvalid", M_AXI_ARVALID, e_ar);
      checkOutput("wvalid", M_AXI_WVALID, e_wv);
      checkOutput("wlast", M_AXI_WLAST, e_wl);
      checkOutput("wr_ready", wr_ready, e_wr);
      checkOutput("bready", M_AXI_BREADY, e_br);
      checkOutput("rready", M_AXI_RREADY, e_rr);
      checkOutput("rd_valid", rd_valid, e_rv);
      checkOutput("rd_last", rd_last, e_rl);
      checkOutput("done", done, m_done_pend);
      if (e_aw) begin
        checkOutput("awaddr", M_AXI_AWADDR, m_addr);
        checkOutput("awlen", M_AXI_AWLEN, 64'(m_len));
        checkOutput("awid", M_AXI_AWID, m_id);
        checkOutput("awsize", M_AXI_AWSIZE, 2);
        checkOutput("awburst", M_AXI_AWBURST, 1);
      end
      if (e_ar) begin
        checkOutput("araddr", M_AXI_ARADDR, m_addr);
        checkOutput("arlen", M_AXI_ARLEN, 64'(m_len));
        checkOutput("arid", M_AXI_ARID, m_id);
        checkOutput("arsize", M_AXI_ARSIZE, 2);
        checkOutput("arburst", M_AXI_ARBURST, 1);
      end
      if (e_wv) begin
        checkOutput("wdata", M_AXI_WDATA, wr_data);
        checkOutput("wstrb", M_AXI_WSTRB, wr_strb);
      end
      if (e_rv) checkOutput("rd_data", rd_data, M_AXI_RDATA);
      if (m_done_pend) begin
        checkOutput("done_resp", resp, m_resp);
        checkOutput("done_err", err, m_err);
      end

      m_done_pend = 0;
      if (!m_busy) begin
        if (cmd_valid) begin
          m_busy = 1; m_write = cmd_write; m_addr = cmd_addr; m_len = int'(cmd_len);
          m_id = cmd_id; m_addr_hs = 0; m_w_done = 0; m_beats = 0;
          m_resp = '0; m_err = 1'b0;
        end
      end else begin
        if ((e_aw && M_AXI_AWREADY) || (e_ar && M_AXI_ARREADY)) m_addr_hs = 1;
        if (e_wv && M_AXI_WREADY) begin
          if (m_beats == m_len) m_w_done = 1;
          m_beats++;
        end
        if (e_br && M_AXI_BVALID) begin
          m_resp = M_AXI_BRESP;
          m_err = (M_AXI_BID != m_id);
          m_busy = 0; m_done_pend = 1;
        end
        if (e_rv && rd_ready) begin
          if (M_AXI_RRESP > m_resp) m_resp = M_AXI_RRESP;
          if (M_AXI_RID != m_id) m_err = 1'b1;
          if (M_AXI_RLAST != (m_beats == m_len)) m_err = 1'b1;
          m_beats++;
          if (M_AXI_RLAST) begin
            m_busy = 0; m_done_pend = 1;
          end
        end
      end
    end
  end

  task automatic setDefaults();
    cfg_aw_stall = 0; cfg_wgaps = 1'b0; cfg_rtoggle = 1'b0;
    cfg_bresp = '0; cfg_bid = '0; cfg_rid = '0;
    cfg_rresp = '0; cfg_rresp_beat = 0; cfg_rlast_at = 0;
  endtask

  task automatic applyStimulus(input logic wr, input logic [31:0] addr,
                               input logic [7:0] len, input logic [3:0] id);
    int n;
    @(posedge ACLK);
    #1;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len; cmd_id = id;
    n = 0;
    @(negedge ACLK);
    while (!cmd_ready && n < 100) begin
      @(negedge ACLK);
      n++;
    end
    checkOutput("cmd_accept", cmd_ready, 1);
    @(posedge ACLK);
    #1;
    cmd_valid = 1'b0;
    hs_cyc = cyc;
  endtask

  task automatic waitDone(input string tag, input int exp_lat,
                          input logic [1:0] exp_resp, input logic exp_err);
    int n;
    n = 0;
    @(negedge ACLK);
    while (!done && n < 400) begin
      @(negedge ACLK);
      n++;
    end
    checkOutput({tag, "_done"}, done, 1);
    if (exp_lat > 0) checkOutput({tag, "_latency"}, 64'(cyc - hs_cyc), 64'(exp_lat));
    checkOutput({tag, "_resp"}, resp, exp_resp);
    checkOutput({tag, "_err"}, err, exp_err);
  endtask

  int hs0, last0;

  initial begin
    setDefaults();
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    checkOutput("init_cmd_ready", cmd_ready, 1);
    checkOutput("init_resp", resp, 0);
    @(posedge ACLK);
    #1;
    ARESETN = 1'b1;

    $display("[TB] write len=3 addr=0x100 id=5, zero-wait slave");
    setDefaults(); cfg_bid = 4'd5;
    applyStimulus(1'b1, 32'h100, 8'd3, 4'd5);
    @(negedge ACLK);
    checkOutput("t1_awvalid", M_AXI_AWVALID, 1);
    checkOutput("t1_awaddr", M_AXI_AWADDR, 32'h100);
    checkOutput("t1_awlen", M_AXI_AWLEN, 3);
    checkOutput("t1_awsize", M_AXI_AWSIZE, 2);
    checkOutput("t1_awburst", M_AXI_AWBURST, 1);
    waitDone("t1", 6, 2'd0, 1'b0);

    $display("[TB] read len=0 with RRESP=2");
    setDefaults(); cfg_rid = 4'd3; cfg_rresp = 2'd2;
    last0 = rd_last_cnt;
    applyStimulus(1'b0, 32'h200, 8'd0, 4'd3);
    waitDone("t2", 2, 2'd2, 1'b0);
    checkOutput("t2_rd_last_beats", 64'(rd_last_cnt - last0), 1);

    $display("[TB] read len=7 with rd_ready toggling");
    setDefaults(); cfg_rid = 4'd7; cfg_rlast_at = 7; cfg_rtoggle = 1'b1;
    cfg_rresp = 2'd1; cfg_rresp_beat = 4;
    hs0 = rd_hs_cnt;
    applyStimulus(1'b0, 32'h1000, 8'd7, 4'd7);
    waitDone("t3", 0, 2'd1, 1'b0);
    checkOutput("t3_rd_handshakes", 64'(rd_hs_cnt - hs0), 8);

    $display("[TB] write with AWREADY stalled 5 cycles and stream gaps");
    setDefaults(); cfg_aw_stall = 5; cfg_wgaps = 1'b1; cfg_bid = 4'd9; cfg_bresp = 2'd1;
    applyStimulus(1'b1, 32'h3F0, 8'd3, 4'd9);
    waitDone("t4", 0, 2'd1, 1'b0);

    $display("[TB] read len=7 with early RLAST on beat 3");
    setDefaults(); cfg_rid = 4'd4; cfg_rlast_at = 2;
    applyStimulus(1'b0, 32'h400, 8'd7, 4'd4);
    waitDone("t5a", 4, 2'd0, 1'b1);

    $display("[TB] read len=1 with wrong RID");
    setDefaults(); cfg_rid = 4'd6; cfg_rlast_at = 1;
    applyStimulus(1'b0, 32'h480, 8'd1, 4'd4);
    waitDone("t5b", 3, 2'd0, 1'b1);

    $display("[TB] write len=1 with wrong BID and SLVERR");
    setDefaults(); cfg_bid = 4'd2; cfg_bresp = 2'd2;
    applyStimulus(1'b1, 32'h500, 8'd1, 4'd8);
    waitDone("t5c", 4, 2'd2, 1'b1);

    $display("[TB] reset pulse during write beat 2");
    setDefaults(); cfg_bid = 4'd1;
    applyStimulus(1'b1, 32'h600, 8'd3, 4'd1);
    @(posedge ACLK);
    #1;
    @(posedge ACLK);
    #1;
    checkOutput("t6_pre_wvalid", M_AXI_WVALID, 1);
    #2;
    ARESETN = 1'b0;
    #1;
    checkOutput("t6_async_wvalid", M_AXI_WVALID, 0);
    checkOutput("t6_async_wlast", M_AXI_WLAST, 0);
    checkOutput("t6_async_wr_ready", wr_ready, 0);
    checkOutput("t6_async_cmd_ready", cmd_ready, 1);
    checkOutput("t6_async_done", done, 0);
    @(posedge ACLK);
    #1;
    @(posedge ACLK);
    #1;
    ARESETN = 1'b1;
    applyStimulus(1'b1, 32'h40, 8'd0, 4'd1);
    waitDone("t6", 3, 2'd0, 1'b0);

    $display("[TB] read len=255 zero-wait");
    setDefaults(); cfg_rid = 4'hA; cfg_rlast_at = 255; cfg_rresp = 2'd3; cfg_rresp_beat = 255;
    applyStimulus(1'b0, 32'h2000, 8'd255, 4'hA);
    waitDone("t7", 257, 2'd3, 1'b0);

    repeat (3) @(posedge ACLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_cmp++;
    n_fail++;
    $display("[TB] FAIL watchdog: still running at %0t, expected to have finished", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
